ray_march_ctrl: RTL and testbench
=================================

Name: ray_march_ctrl

Overview:
- Drives the step parameter `p` into the position unit (get_pos) and consumes the position it returns one cycle later.
- Per returned position: computes the maze cell, reads the wall map and decides the hit.
- Searches coarse-then-fine for the smallest `p` that hits.
- Sits between the per-pixel ray setup (which supplies ori/dir straight to get_pos) and the shading stage, which consumes `hit_p`/`hit_kind`.

Parameters:
- COARSE_STEP, 8, coarse stride of `p` (power of two, 2..64)
- CELL_SHIFT, 6, log2 of cell size in position units
- MAP_W, 16, maze width in cells
- MAP_H, 16, maze height in cells
- Z_MAX, 64, exclusive upper bound of valid z (floor at 0)
- ADDR_W, 8, map address width (at least clog2(MAP_W*MAP_H))

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- start  in  1  pulse: begin a march; ignored while busy=1
- busy  out  1  high from cycle after accepted start until done
- done  out  1  one-cycle pulse when result valid
- hit  out  1  1 = surface found, 0 = miss
- hit_kind  out  2  0 none, 1 wall, 2 out-of-map, 3 floor/ceiling
- hit_p  out  10  `p` of first hit; 1023 on miss
- hit_cell  out  ADDR_W  map address of hit cell (0 unless kind=1)
- p_out  out  19  step parameter to get_pos
- pos_x, pos_y, pos_z  in  12 signed  get_pos outputs (integer position)
- pos_p  in  10  get_pos echoed `p`; 1023 = saturated
- map_addr  out  ADDR_W  wall map read address
- map_wall  in  1  wall bit for map_addr, 1-cycle read latency

Behaviour:
- Reset (rst_n=0 at an edge): all outputs 0, FSM in IDLE, pipeline valids cleared.
- Reset mid-march aborts with no done pulse.
- FSM states: IDLE, COARSE, DRAIN_C, FINE, DRAIN_F, DONE.
  - IDLE: on start, go to COARSE with next_p=0 and busy=1.
  - COARSE: each cycle, p_out <= next_p, issue valid, next_p += COARSE_STEP.
  - COARSE → DRAIN_C when next_p would exceed 1023.
  - COARSE or DRAIN_C, first hit at stage S2 with p=ph: flush all in-flight entries.
    - go to FINE with next_p = max(0, ph-COARSE_STEP+1), fine_end = ph.
  - DRAIN_C, pipeline empty with no hit: DONE with hit=0, hit_kind=0, hit_p=1023.
  - FINE: step 1 up to fine_end, then DRAIN_F; the first S2 hit flushes and goes to DONE.
    - a hit at fine_end is guaranteed because the map is static during a march.
  - DONE: register results, done=1 for one cycle, busy=0, back to IDLE.
- Results hold until the next accepted start.
- Probe pipeline (3 stages, one probe per cycle, results in order):
  - S0: p_out registered; get_pos answers on pos_* in the next cycle.
  - S1: register the following; drive map_addr = cy*MAP_W + cx.
    - cx = pos_x >>> CELL_SHIFT, cy = pos_y >>> CELL_SHIFT
    - oom flag = pos_x<0 | pos_y<0 | cx>=MAP_W | cy>=MAP_H | pos_p==1023
    - fc flag = pos_z<0 | pos_z>=Z_MAX
    - p tag
  - S2: map_wall valid. Classification, priority oom > fc > wall:
    - oom with pos_p==1023 → treated as miss, not a hit
    - other oom → kind 2
    - fc → kind 3
    - wall → kind 1
- An S2 hit in the same cycle as the last COARSE issue: the hit wins and the issue is flushed.
- Only the first (lowest-p) hit is used. Later in-flight probes are discarded via valid clear; flushing never stalls.
- Width rules:
  - next_p is 11-bit to detect overflow past 1023.
  - p_out[18:10] = 0 always.
  - cx/cy compare done signed.
- start during busy: ignored, no state change.

Decomposition:
- maze_pkg holds:
  - hit_kind codes (HK_NONE/HK_WALL/HK_OOM/HK_FC)
  - P_MAX=1023 and the P_SAT sentinel
  - FSM state encoding
- One natural sub-module, ray_probe_pipe: the S0–S2 valid/tag/flag shift pipeline with a flush input.
  - FSM and result registers stay in ray_march_ctrl.

Test Plan:
- Empty 16x16 map, ori=(64,64,10), dir=+x small enough to stay in map until p saturates → done within 140 cycles of start; hit=0, hit_kind=0, hit_p=1023.
- Wall at cell (5,1), ori=(64,64,10), dir_x=256 (1.0) → coarse hit at p=256, fine resolves hit_p=256, hit_kind=1, hit_cell=21.
- Same setup, ori_x=70 → first wall entry at p=250 is inside coarse interval (248,256] → hit_p=250 (not 256).
- dir=-x from ori_x=10 → pos_x<0 at p=11 → hit_kind=2, hit_p=11, hit_cell=0.
- dir_z=-256 from z=5, empty map → hit_kind=3, hit_p=6.
- start pulsed again mid-march is ignored, result unchanged. rst_n low for one cycle mid-COARSE → all outputs 0, no done; a new start then completes normally.

Source files
------------

// File: rtl/maze_pkg.sv
// Shared encodings for the ray-march controller: hit kinds, p sentinels, FSM states.
package maze_pkg;

    localparam logic [9:0] P_MAX = 10'd1023;
    localparam logic [9:0] P_SAT = 10'd1023;

    typedef enum logic [1:0] {
        HK_NONE = 2'd0,
        HK_WALL = 2'd1,
        HK_OOM  = 2'd2,
        HK_FC   = 2'd3
    } hit_kind_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COARSE,
        ST_DRAIN_C,
        ST_FINE,
        ST_DRAIN_F,
        ST_DONE
    } state_t;

    // A saturated get_pos answer is flagged out-of-map but must never count as a hit.
    function automatic hit_kind_t classify(input logic oom, input logic sat,
                                           input logic fc, input logic wall);
        if (oom) return sat ? HK_NONE : HK_OOM;
        if (fc) return HK_FC;
        if (wall) return HK_WALL;
        return HK_NONE;
    endfunction

endpackage

// File: rtl/ray_march_ctrl_if.sv
// Control, get_pos and wall-map signals of the ray-march controller bundled as one port.
interface ray_march_ctrl_if #(parameter int ADDR_W = 8);

    logic                start;
    logic                busy;
    logic                done;
    logic                hit;
    logic [1:0]          hit_kind;
    logic [9:0]          hit_p;
    logic [ADDR_W-1:0]   hit_cell;
    logic [18:0]         p_out;
    logic signed [11:0]  pos_x;
    logic signed [11:0]  pos_y;
    logic signed [11:0]  pos_z;
    logic [9:0]          pos_p;
    logic [ADDR_W-1:0]   map_addr;
    logic                map_wall;

    modport master (
        input  start, pos_x, pos_y, pos_z, pos_p, map_wall,
        output busy, done, hit, hit_kind, hit_p, hit_cell, p_out, map_addr
    );

    modport slave (
        output start, pos_x, pos_y, pos_z, pos_p, map_wall,
        input  busy, done, hit, hit_kind, hit_p, hit_cell, p_out, map_addr
    );

endinterface

// File: rtl/ray_probe_pipe.sv
// Three-stage probe pipeline: align p with get_pos, compute cell/flags, meet the map read.
module ray_probe_pipe
    import maze_pkg::*;
#(
    parameter int CELL_SHIFT = 6,
    parameter int MAP_W      = 16,
    parameter int MAP_H      = 16,
    parameter int Z_MAX      = 64,
    parameter int ADDR_W     = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                issue_valid,
    input  logic [9:0]          issue_p,
    input  logic signed [11:0]  pos_x,
    input  logic signed [11:0]  pos_y,
    input  logic signed [11:0]  pos_z,
    input  logic [9:0]          pos_p,
    output logic [ADDR_W-1:0]   map_addr,
    output logic                s2_valid,
    output logic [9:0]          s2_p,
    output logic                s2_oom,
    output logic                s2_sat,
    output logic                s2_fc,
    output logic [ADDR_W-1:0]   s2_cell,
    output logic                any_valid
);

    localparam logic signed [11:0] MAP_W_S = 12'(MAP_W);
    localparam logic signed [11:0] MAP_H_S = 12'(MAP_H);
    localparam logic signed [11:0] Z_MAX_S = 12'(Z_MAX);

    logic signed [11:0] cx, cy;
    logic               oom_c, sat_c, fc_c;
    logic [ADDR_W-1:0]  addr_c;

    logic               s0_valid, s1_valid;
    logic [9:0]         s0_p, s1_p;
    logic               s1_oom, s1_sat, s1_fc;

    assign cx     = pos_x >>> CELL_SHIFT;
    assign cy     = pos_y >>> CELL_SHIFT;
    assign sat_c  = (pos_p == P_SAT);
    assign oom_c  = (pos_x < 0) || (pos_y < 0) || (cx >= MAP_W_S) || (cy >= MAP_H_S) || sat_c;
    assign fc_c   = (pos_z < 0) || (pos_z >= Z_MAX_S);
    assign addr_c = ADDR_W'(int'(cy) * MAP_W + int'(cx));

    // Flush only kills valids; tags and flags of dead entries are harmless.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s0_valid <= 1'b0;
            s0_p     <= '0;
            s1_valid <= 1'b0;
            s1_p     <= '0;
            s1_oom   <= 1'b0;
            s1_sat   <= 1'b0;
            s1_fc    <= 1'b0;
            map_addr <= '0;
            s2_valid <= 1'b0;
            s2_p     <= '0;
            s2_oom   <= 1'b0;
            s2_sat   <= 1'b0;
            s2_fc    <= 1'b0;
            s2_cell  <= '0;
        end else begin
            s0_valid <= issue_valid && !flush;
            s0_p     <= issue_p;
            s1_valid <= s0_valid && !flush;
            s1_p     <= s0_p;
            s1_oom   <= oom_c;
            s1_sat   <= sat_c;
            s1_fc    <= fc_c;
            map_addr <= addr_c;
            s2_valid <= s1_valid && !flush;
            s2_p     <= s1_p;
            s2_oom   <= s1_oom;
            s2_sat   <= s1_sat;
            s2_fc    <= s1_fc;
            s2_cell  <= map_addr;
        end
    end

    assign any_valid = s0_valid || s1_valid || s2_valid;

endmodule

// File: rtl/ray_march_ctrl.sv
// Coarse-then-fine search for the smallest step p whose probe hits a wall, map edge or floor/ceiling.
module ray_march_ctrl
    import maze_pkg::*;
#(
    parameter int COARSE_STEP = 8,
    parameter int CELL_SHIFT  = 6,
    parameter int MAP_W       = 16,
    parameter int MAP_H       = 16,
    parameter int Z_MAX       = 64,
    parameter int ADDR_W      = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    ray_march_ctrl_if.master bus
);

    state_t             state;
    logic [10:0]        next_p;
    logic [9:0]         fine_end;
    logic               iss_valid;
    logic [9:0]         iss_p;
    hit_kind_t          pend_kind;
    logic [9:0]         pend_p;
    logic [ADDR_W-1:0]  pend_cell;

    logic               busy_r, done_r, hit_r;
    logic [1:0]         kind_r;
    logic [9:0]         hit_p_r;
    logic [ADDR_W-1:0]  cell_r;

    logic               s2_valid, s2_oom, s2_sat, s2_fc, pipe_any;
    logic [9:0]         s2_p;
    logic [ADDR_W-1:0]  s2_cell;
    hit_kind_t          s2_kind;
    logic               s2_hit;
    logic [10:0]        fine_start;
    logic               pipe_empty;

    ray_probe_pipe #(
        .CELL_SHIFT (CELL_SHIFT),
        .MAP_W      (MAP_W),
        .MAP_H      (MAP_H),
        .Z_MAX      (Z_MAX),
        .ADDR_W     (ADDR_W)
    ) u_pipe (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (s2_hit),
        .issue_valid (iss_valid),
        .issue_p     (iss_p),
        .pos_x       (bus.pos_x),
        .pos_y       (bus.pos_y),
        .pos_z       (bus.pos_z),
        .pos_p       (bus.pos_p),
        .map_addr    (bus.map_addr),
        .s2_valid    (s2_valid),
        .s2_p        (s2_p),
        .s2_oom      (s2_oom),
        .s2_sat      (s2_sat),
        .s2_fc       (s2_fc),
        .s2_cell     (s2_cell),
        .any_valid   (pipe_any)
    );

    assign s2_kind    = classify(s2_oom, s2_sat, s2_fc, bus.map_wall);
    assign s2_hit     = s2_valid && (s2_kind != HK_NONE);
    assign pipe_empty = !iss_valid && !pipe_any;
    // Fine window is (ph-COARSE_STEP, ph], clamped at zero.
    assign fine_start = ({1'b0, s2_p} + 11'd1 > 11'(COARSE_STEP))
                        ? ({1'b0, s2_p} + 11'd1 - 11'(COARSE_STEP)) : 11'd0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            next_p    <= '0;
            fine_end  <= '0;
            iss_valid <= 1'b0;
            iss_p     <= '0;
            pend_kind <= HK_NONE;
            pend_p    <= '0;
            pend_cell <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            hit_r     <= 1'b0;
            kind_r    <= '0;
            hit_p_r   <= '0;
            cell_r    <= '0;
        end else begin
            done_r    <= 1'b0;
            iss_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        state  <= ST_COARSE;
                        next_p <= '0;
                        busy_r <= 1'b1;
                    end
                end
                ST_COARSE, ST_DRAIN_C: begin
                    if (s2_hit) begin
                        state    <= ST_FINE;
                        next_p   <= fine_start;
                        fine_end <= s2_p;
                    end else if (state == ST_COARSE) begin
                        iss_p     <= next_p[9:0];
                        iss_valid <= 1'b1;
                        next_p    <= next_p + 11'(COARSE_STEP);
                        if (next_p + 11'(COARSE_STEP) > {1'b0, P_MAX})
                            state <= ST_DRAIN_C;
                    end else if (pipe_empty) begin
                        state     <= ST_DONE;
                        pend_kind <= HK_NONE;
                        pend_p    <= P_MAX;
                        pend_cell <= '0;
                    end
                end
                ST_FINE, ST_DRAIN_F: begin
                    if (s2_hit) begin
                        state     <= ST_DONE;
                        pend_kind <= s2_kind;
                        pend_p    <= s2_p;
                        pend_cell <= (s2_kind == HK_WALL) ? s2_cell : '0;
                    end else if (state == ST_FINE) begin
                        iss_p     <= next_p[9:0];
                        iss_valid <= 1'b1;
                        next_p    <= next_p + 11'd1;
                        if (next_p[9:0] == fine_end)
                            state <= ST_DRAIN_F;
                    end else if (pipe_empty) begin
                        state     <= ST_DONE;
                        pend_kind <= HK_NONE;
                        pend_p    <= P_MAX;
                        pend_cell <= '0;
                    end
                end
                ST_DONE: begin
                    state   <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b1;
                    hit_r   <= (pend_kind != HK_NONE);
                    kind_r  <= pend_kind;
                    hit_p_r <= pend_p;
                    cell_r  <= pend_cell;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.p_out    = {9'd0, iss_p};
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.hit      = hit_r;
    assign bus.hit_kind = kind_r;
    assign bus.hit_p    = hit_p_r;
    assign bus.hit_cell = cell_r;

endmodule

// File: tb/tb_ray_march_ctrl.sv
// Directed vector bench for ray_march_ctrl with behavioural get_pos and wall-map responders.
module tb_ray_march_ctrl;

    typedef struct {
        string name;
        int    ox, oy, oz;
        int    dx, dy, dz;
        int    wall;
        int    sat_from;
        int    max_cyc;
        int    exp_hit, exp_kind, exp_p, exp_cell;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ray_march_ctrl_if #(.ADDR_W(8)) bus ();

    ray_march_ctrl #(
        .COARSE_STEP (8),
        .CELL_SHIFT  (6),
        .MAP_W       (16),
        .MAP_H       (16),
        .Z_MAX       (64),
        .ADDR_W      (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    int ori_x = 0, ori_y = 0, ori_z = 0;
    int dir_x = 0, dir_y = 0, dir_z = 0;
    int sat_from = 1024;
    logic [255:0] wall_map = '0;

    int total = 0;
    int bad = 0;
    vec_t vq[$];

    // get_pos: position = ori + dir*p/256, answered one cycle after p_out.
    always @(posedge clk) begin
        int p;
        p = int'(bus.p_out[9:0]);
        bus.pos_x <= 12'(ori_x + ((dir_x * p) >>> 8));
        bus.pos_y <= 12'(ori_y + ((dir_y * p) >>> 8));
        bus.pos_z <= 12'(ori_z + ((dir_z * p) >>> 8));
        bus.pos_p <= (p >= sat_from) ? 10'd1023 : bus.p_out[9:0];
    end

    always @(posedge clk) bus.map_wall <= wall_map[bus.map_addr];

    function automatic vec_t mk(string n, int ox, int oy, int oz, int dx, int dy, int dz,
                                int wall, int sat, int maxc, int eh, int ek, int ep, int ec);
        vec_t v;
        v.name = n; v.ox = ox; v.oy = oy; v.oz = oz; v.dx = dx; v.dy = dy; v.dz = dz;
        v.wall = wall; v.sat_from = sat; v.max_cyc = maxc;
        v.exp_hit = eh; v.exp_kind = ek; v.exp_p = ep; v.exp_cell = ec;
        return v;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic setupEnv(input vec_t v);
        ori_x = v.ox; ori_y = v.oy; ori_z = v.oz;
        dir_x = v.dx; dir_y = v.dy; dir_z = v.dz;
        sat_from = v.sat_from;
        wall_map = '0;
        if (v.wall >= 0) wall_map[v.wall] = 1'b1;
    endtask

    task automatic pulseStart();
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic waitDone(input int budget, output int cycles, output int timed_out);
        cycles = 0;
        timed_out = 1;
        while (cycles < budget) begin
            @(posedge clk);
            #1;
            cycles++;
            if (bus.done) begin
                timed_out = 0;
                break;
            end
        end
    endtask

    task automatic checkResult(input vec_t v);
        checkOutput({v.name, "_hit"}, int'(bus.hit), v.exp_hit);
        checkOutput({v.name, "_kind"}, int'(bus.hit_kind), v.exp_kind);
        checkOutput({v.name, "_p"}, int'(bus.hit_p), v.exp_p);
        checkOutput({v.name, "_cell"}, int'(bus.hit_cell), v.exp_cell);
    endtask

    task automatic applyStimulus(input vec_t v);
        int cycles, timed_out;
        setupEnv(v);
        pulseStart();
        waitDone(2000, cycles, timed_out);
        checkOutput({v.name, "_timeout"}, timed_out, 0);
        checkOutput({v.name, "_latency_ok"}, int'(cycles <= v.max_cyc), 1);
        checkResult(v);
        @(posedge clk);
        #1;
        checkOutput({v.name, "_done_pulse"}, int'({bus.done, bus.busy}), 0);
        checkOutput({v.name, "_hold_p"}, int'(bus.hit_p), v.exp_p);
    endtask

    task automatic checkAllZero(input string name);
        checkOutput({name, "_ctl_zero"},
                    int'({bus.busy, bus.done, bus.hit, bus.hit_kind, bus.hit_p, bus.hit_cell}), 0);
        checkOutput({name, "_bus_zero"}, int'({bus.p_out, bus.map_addr}), 0);
    endtask

    initial begin
        int cycles, timed_out, done_cnt;
        bus.start = 1'b0;

        vq.push_back(mk("empty_px",     64, 64, 10,  16,   0,    0,  -1, 1024,  140, 0, 0, 1023, 0));
        vq.push_back(mk("wall_256",     64, 64, 10, 256,   0,    0,  21, 1024, 2000, 1, 1,  256, 21));
        vq.push_back(mk("wall_250",     70, 64, 10, 256,   0,    0,  21, 1024, 2000, 1, 1,  250, 21));
        vq.push_back(mk("oom_negx",     10, 64, 10, -256,  0,    0,  -1, 1024, 2000, 1, 2,   11, 0));
        vq.push_back(mk("fc_negz",      64, 64,  5,   0,   0, -256,  -1, 1024, 2000, 1, 3,    6, 0));
        vq.push_back(mk("fc_zmax",      64, 64, 63,   0,   0,  256,  -1, 1024, 2000, 1, 3,    1, 0));
        vq.push_back(mk("fc_at_p0",     64, 64, -1,   0,   0,    0,  -1, 1024, 2000, 1, 3,    0, 0));
        vq.push_back(mk("prio_oom_fc",  -5, 64, -5,   0,   0,    0,  -1, 1024, 2000, 1, 2,    0, 0));
        vq.push_back(mk("prio_fc_wall", 64, 64, -1,   0,   0,    0,  17, 1024, 2000, 1, 3,    0, 0));
        vq.push_back(mk("sat_miss",     64, 64, 10, 256,   0,    0,  -1,  900, 2000, 0, 0, 1023, 0));
        vq.push_back(mk("oom_posy",     64, 64, 10,   0, 256,    0,  -1, 1024, 2000, 1, 2,  960, 0));
        vq.push_back(mk("hit_last_iss", 75, 64, 10,  64,   0,    0,  21, 1024, 2000, 1, 1,  980, 21));

        repeat (2) @(posedge clk);
        #1;
        checkAllZero("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < vq.size(); i++) applyStimulus(vq[i]);

        // A second start while busy must leave the march and its result untouched.
        setupEnv(vq[1]);
        pulseStart();
        repeat (20) @(posedge clk);
        #1;
        checkOutput("busy_mid_march", int'(bus.busy), 1);
        pulseStart();
        waitDone(2000, cycles, timed_out);
        checkOutput("restart_timeout", timed_out, 0);
        checkResult(vq[1]);
        done_cnt = 0;
        repeat (60) begin
            @(posedge clk);
            #1;
            if (bus.done) done_cnt++;
        end
        checkOutput("restart_extra_done", done_cnt, 0);

        // Reset in the middle of a coarse sweep: no done, everything back to zero.
        setupEnv(vq[0]);
        pulseStart();
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;
        checkAllZero("mid_reset");
        rst_n = 1'b1;
        done_cnt = 0;
        repeat (200) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) done_cnt++;
        end
        checkOutput("mid_reset_no_done", done_cnt, 0);
        applyStimulus(vq[3]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
